// File: rtl/pux_pkg.sv
// Shared types and constants for the PUX opcode sequencer.
// Holds the FSM state enum, the status codes and the opcode field positions.
package pux_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        LOAD,
        START,
        WAIT,
        REPORT
    } state_t;

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_CORE_ERR = 2'b01;
    localparam logic [1:0] ST_TIMEOUT  = 2'b10;
    localparam logic [1:0] ST_ILLEGAL  = 2'b11;

    localparam int unsigned MASK_A = 0;
    localparam int unsigned MASK_B = 1;
    localparam int unsigned MASK_M = 2;
    localparam int unsigned OP_LSB = 3;

    function automatic int unsigned widx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pux_opnd_gather.sv
// Lockstep join of the A/B/M operand streams; one beat only when every enabled
// stream is valid. Emits core_wr/core_widx one cycle after each accepted beat.
module pux_opnd_gather
    import pux_pkg::*;
#(
    parameter int unsigned DATAW  = 16,
    parameter int unsigned NWORDS = 4,
    parameter int unsigned WIDXW  = 2
) (
    input  logic             axis_clk,
    input  logic             axis_rstn,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [2:0]       i_mask,
    input  logic [DATAW-1:0] i_a_data,
    input  logic [DATAW-1:0] i_b_data,
    input  logic [DATAW-1:0] i_m_data,
    input  logic             i_a_valid,
    input  logic             i_b_valid,
    input  logic             i_m_valid,
    output logic             o_a_ready,
    output logic             o_b_ready,
    output logic             o_m_ready,
    output logic [DATAW-1:0] o_a,
    output logic [DATAW-1:0] o_b,
    output logic [DATAW-1:0] o_m,
    output logic             o_wr,
    output logic [WIDXW-1:0] o_widx,
    output logic             o_last
);

    logic             w_all_v;
    logic [WIDXW-1:0] r_cnt;
    logic [WIDXW-1:0] r_widx;
    logic             r_wr;
    logic [DATAW-1:0] r_a;
    logic [DATAW-1:0] r_b;
    logic [DATAW-1:0] r_m;

    // Disabled streams count as always valid so they never stall the join.
    assign w_all_v = i_en
                   & (~i_mask[MASK_A] | i_a_valid)
                   & (~i_mask[MASK_B] | i_b_valid)
                   & (~i_mask[MASK_M] | i_m_valid);

    assign o_a_ready = w_all_v & i_mask[MASK_A];
    assign o_b_ready = w_all_v & i_mask[MASK_B];
    assign o_m_ready = w_all_v & i_mask[MASK_M];
    assign o_last    = w_all_v && (r_cnt == WIDXW'(NWORDS - 1));

    always_ff @(posedge axis_clk or negedge axis_rstn) begin
        if (!axis_rstn) begin
            r_cnt  <= '0;
            r_widx <= '0;
            r_wr   <= 1'b0;
            r_a    <= '0;
            r_b    <= '0;
            r_m    <= '0;
        end else begin
            r_wr <= w_all_v;
            if (i_clr) begin
                r_cnt <= '0;
            end else if (w_all_v) begin
                r_a    <= i_mask[MASK_A] ? i_a_data : '0;
                r_b    <= i_mask[MASK_B] ? i_b_data : '0;
                r_m    <= i_mask[MASK_M] ? i_m_data : '0;
                r_widx <= r_cnt;
                r_cnt  <= o_last ? '0 : r_cnt + WIDXW'(1);
            end
        end
    end

    assign o_wr   = r_wr;
    assign o_widx = r_widx;
    assign o_a    = r_a;
    assign o_b    = r_b;
    assign o_m    = r_m;

endmodule

// File: rtl/pux_opseq.sv
// PUX opcode sequencer: opcode decode, operand gather, core start/done/timeout, status report.
// Optional PUX_OPSEQ_PERF_EN adds perf_ops / perf_busy counters.
module pux_opseq
    import pux_pkg::*;
#(
    parameter  int unsigned OPCW    = 8,
    parameter  int unsigned DATAW   = 16,
    parameter  int unsigned STATUSW = 2,
    parameter  int unsigned NWORDS  = 4,
    parameter  int unsigned TOUTW   = 8,
    localparam int unsigned WIDXW   = widx_width(NWORDS)
) (
    input  logic                   axis_clk,
    input  logic                   axis_rstn,
    input  logic [OPCW-1:0]        axis_opcode_data,
    input  logic                   axis_opcode_valid,
    output logic                   axis_opcode_ready,
    input  logic [DATAW-1:0]       axis_abuff_data,
    input  logic [DATAW-1:0]       axis_bbuff_data,
    input  logic [DATAW-1:0]       axis_mbuff_data,
    input  logic                   axis_abuff_valid,
    input  logic                   axis_bbuff_valid,
    input  logic                   axis_mbuff_valid,
    output logic                   axis_abuff_ready,
    output logic                   axis_bbuff_ready,
    output logic                   axis_mbuff_ready,
    output logic [OPCW-OP_LSB-1:0] core_op,
    output logic                   core_wr,
    output logic [WIDXW-1:0]       core_widx,
    output logic [DATAW-1:0]       core_a,
    output logic [DATAW-1:0]       core_b,
    output logic [DATAW-1:0]       core_m,
    output logic                   core_start,
    input  logic                   core_done,
    input  logic                   core_err,
    output logic                   core_abort,
    output logic [STATUSW-1:0]     axis_status_data,
    output logic                   axis_status_valid,
    input  logic                   axis_status_ready
`ifdef PUX_OPSEQ_PERF_EN
    ,
    output logic [31:0]            perf_ops,
    output logic [31:0]            perf_busy
`endif
);

    state_t             r_state;
    state_t             w_next;
    logic [OPCW-1:0]    r_opc;
    logic               r_opc_ready;
    logic [TOUTW-1:0]   r_tout;
    logic [STATUSW-1:0] r_status;
    logic [2:0]         w_mask;
    logic               w_tout_sat;
    logic               w_last;
    logic               w_status_hs;

    assign w_mask      = r_opc[2:0];
    assign w_tout_sat  = &r_tout;
    assign w_status_hs = (r_state == REPORT) && axis_status_ready;

    always_ff @(posedge axis_clk or negedge axis_rstn) begin
        if (!axis_rstn) r_state <= IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (axis_opcode_valid && r_opc_ready) w_next = DECODE;
            DECODE:  w_next = (w_mask == 3'b000) ? REPORT : LOAD;
            LOAD:    if (w_last) w_next = START;
            START:   w_next = WAIT;
            WAIT:    if (core_done || w_tout_sat) w_next = REPORT;
            REPORT:  if (axis_status_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        axis_opcode_ready = r_opc_ready;
        core_start        = (r_state == START);
        core_abort        = (r_state == WAIT) && w_tout_sat && !core_done;
        axis_status_valid = (r_state == REPORT);
    end

    // Ready is registered from the next state so it stays low while reset is held
    // and rises only in the cycle after the status handshake.
    always_ff @(posedge axis_clk or negedge axis_rstn) begin
        if (!axis_rstn) begin
            r_opc_ready <= 1'b0;
            r_opc       <= '0;
            r_tout      <= '0;
            r_status    <= '0;
        end else begin
            r_opc_ready <= (w_next == IDLE);
            if (r_state == IDLE && axis_opcode_valid && r_opc_ready)
                r_opc <= axis_opcode_data;
            if (r_state == START)
                r_tout <= '0;
            else if (r_state == WAIT && !w_tout_sat)
                r_tout <= r_tout + TOUTW'(1);
            if (r_state == DECODE && w_mask == 3'b000)
                r_status <= STATUSW'((r_opc == '0) ? ST_OK : ST_ILLEGAL);
            else if (r_state == WAIT && core_done)
                r_status <= STATUSW'(core_err ? ST_CORE_ERR : ST_OK);
            else if (r_state == WAIT && w_tout_sat)
                r_status <= STATUSW'(ST_TIMEOUT);
        end
    end

    assign core_op          = r_opc[OPCW-1:OP_LSB];
    assign axis_status_data = r_status;

    pux_opnd_gather #(
        .DATAW  (DATAW),
        .NWORDS (NWORDS),
        .WIDXW  (WIDXW)
    ) u_gather (
        .axis_clk  (axis_clk),
        .axis_rstn (axis_rstn),
        .i_en      (r_state == LOAD),
        .i_clr     (r_state == DECODE),
        .i_mask    (w_mask),
        .i_a_data  (axis_abuff_data),
        .i_b_data  (axis_bbuff_data),
        .i_m_data  (axis_mbuff_data),
        .i_a_valid (axis_abuff_valid),
        .i_b_valid (axis_bbuff_valid),
        .i_m_valid (axis_mbuff_valid),
        .o_a_ready (axis_abuff_ready),
        .o_b_ready (axis_bbuff_ready),
        .o_m_ready (axis_mbuff_ready),
        .o_a       (core_a),
        .o_b       (core_b),
        .o_m       (core_m),
        .o_wr      (core_wr),
        .o_widx    (core_widx),
        .o_last    (w_last)
    );

`ifdef PUX_OPSEQ_PERF_EN
    logic [31:0] r_perf_ops;
    logic [31:0] r_perf_busy;

    always_ff @(posedge axis_clk or negedge axis_rstn) begin
        if (!axis_rstn) begin
            r_perf_ops  <= '0;
            r_perf_busy <= '0;
        end else begin
            if (w_status_hs)       r_perf_ops  <= r_perf_ops + 32'd1;
            if (r_state != IDLE)   r_perf_busy <= r_perf_busy + 32'd1;
        end
    end

    assign perf_ops  = r_perf_ops;
    assign perf_busy = r_perf_busy;
`endif

endmodule

// File: tb/tb_pux_opseq.sv
// Scoreboard bench for pux_opseq: expected words/status queued at stimulus time,
// popped when core_wr or the status handshake appears.
module tb_pux_opseq;

    localparam int unsigned OPCW    = 8;
    localparam int unsigned DATAW   = 16;
    localparam int unsigned STATUSW = 2;
    localparam int unsigned NWORDS  = 4;
    localparam int unsigned TOUTW   = 8;
    localparam int unsigned WIDXW   = 2;

    logic               axis_clk = 1'b0;
    logic               axis_rstn;
    logic [OPCW-1:0]    axis_opcode_data;
    logic               axis_opcode_valid;
    logic               axis_opcode_ready;
    logic [DATAW-1:0]   axis_abuff_data, axis_bbuff_data, axis_mbuff_data;
    logic               axis_abuff_valid, axis_bbuff_valid, axis_mbuff_valid;
    logic               axis_abuff_ready, axis_bbuff_ready, axis_mbuff_ready;
    logic [OPCW-4:0]    core_op;
    logic               core_wr;
    logic [WIDXW-1:0]   core_widx;
    logic [DATAW-1:0]   core_a, core_b, core_m;
    logic               core_start;
    logic               core_done;
    logic               core_err;
    logic               core_abort;
    logic [STATUSW-1:0] axis_status_data;
    logic               axis_status_valid;
    logic               axis_status_ready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATAW-1:0]   qa[$];
    logic [DATAW-1:0]   qb[$];
    logic [DATAW-1:0]   qm[$];
    logic [WIDXW-1:0]   qw[$];
    logic [STATUSW-1:0] qs[$];

    pux_opseq #(
        .OPCW    (OPCW),
        .DATAW   (DATAW),
        .STATUSW (STATUSW),
        .NWORDS  (NWORDS),
        .TOUTW   (TOUTW)
    ) dut (
        .axis_clk          (axis_clk),
        .axis_rstn         (axis_rstn),
        .axis_opcode_data  (axis_opcode_data),
        .axis_opcode_valid (axis_opcode_valid),
        .axis_opcode_ready (axis_opcode_ready),
        .axis_abuff_data   (axis_abuff_data),
        .axis_bbuff_data   (axis_bbuff_data),
        .axis_mbuff_data   (axis_mbuff_data),
        .axis_abuff_valid  (axis_abuff_valid),
        .axis_bbuff_valid  (axis_bbuff_valid),
        .axis_mbuff_valid  (axis_mbuff_valid),
        .axis_abuff_ready  (axis_abuff_ready),
        .axis_bbuff_ready  (axis_bbuff_ready),
        .axis_mbuff_ready  (axis_mbuff_ready),
        .core_op           (core_op),
        .core_wr           (core_wr),
        .core_widx         (core_widx),
        .core_a            (core_a),
        .core_b            (core_b),
        .core_m            (core_m),
        .core_start        (core_start),
        .core_done         (core_done),
        .core_err          (core_err),
        .core_abort        (core_abort),
        .axis_status_data  (axis_status_data),
        .axis_status_valid (axis_status_valid),
        .axis_status_ready (axis_status_ready)
    );

    always #5 axis_clk = ~axis_clk;

    task automatic idle_inputs();
        axis_opcode_data  = '0;
        axis_opcode_valid = 1'b0;
        axis_abuff_data   = '0;
        axis_bbuff_data   = '0;
        axis_mbuff_data   = '0;
        axis_abuff_valid  = 1'b0;
        axis_bbuff_valid  = 1'b0;
        axis_mbuff_valid  = 1'b0;
        core_done         = 1'b0;
        core_err          = 1'b0;
        axis_status_ready = 1'b0;
    endtask

    // One opcode from issue to status handshake. Iteration 0 presents the opcode;
    // outputs are sampled on negedges, inputs change right after sampling.
    task automatic run_op(input logic [7:0] opc, input int b_delay, input int done_after,
                          input logic err, input int sr_delay, input bit hold_opc,
                          output int n_wr, output int n_start, output int n_abort,
                          output int abort_at, output int lat, output int first_wr);
        logic [DATAW-1:0]   wa [NWORDS];
        logic [DATAW-1:0]   wb [NWORDS];
        logic [DATAW-1:0]   wm [NWORDS];
        logic [2:0]         mask;
        logic [STATUSW-1:0] exp_s, held, got_s;
        logic [DATAW-1:0]   ea, eb, em;
        logic [WIDXW-1:0]   ew;
        int ia, ib, im, acc_it, st_it, sv_it, it;
        bit acc, fin, all_v;
        mask = opc[2:0];
        ia = 0; ib = 0; im = 0; acc = 0; fin = 0;
        acc_it = -1; st_it = -1; sv_it = -1;
        n_wr = 0; n_start = 0; n_abort = 0; abort_at = -1; lat = -1; first_wr = -1;
        held = '0;
        for (int i = 0; i < NWORDS; i++) begin
            wa[i] = DATAW'($urandom);
            wb[i] = DATAW'($urandom);
            wm[i] = DATAW'($urandom);
            if (mask != 3'b000) begin
                qa.push_back(mask[0] ? wa[i] : '0);
                qb.push_back(mask[1] ? wb[i] : '0);
                qm.push_back(mask[2] ? wm[i] : '0);
                qw.push_back(WIDXW'(i));
            end
        end
        if (mask == 3'b000)      exp_s = (opc == 8'h00) ? 2'b00 : 2'b11;
        else if (done_after < 0) exp_s = 2'b10;
        else                     exp_s = err ? 2'b01 : 2'b00;
        qs.push_back(exp_s);
        it = 0;
        while (!fin && it < 700) begin
            @(negedge axis_clk);
            if (core_wr) begin
                n_wr++;
                if (first_wr < 0) first_wr = it;
                if (qw.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL wr_unexpected: core_wr at iter %0d with empty scoreboard", it);
                end else begin
                    ea = qa.pop_front(); eb = qb.pop_front(); em = qm.pop_front(); ew = qw.pop_front();
                    n_tests++;
                    if (core_widx !== ew) begin n_fail++; $display("FAIL widx: got %0d expected %0d", core_widx, ew); end
                    n_tests++;
                    if (core_a !== ea) begin n_fail++; $display("FAIL core_a[%0d]: got %h expected %h", ew, core_a, ea); end
                    n_tests++;
                    if (core_b !== eb) begin n_fail++; $display("FAIL core_b[%0d]: got %h expected %h", ew, core_b, eb); end
                    n_tests++;
                    if (core_m !== em) begin n_fail++; $display("FAIL core_m[%0d]: got %h expected %h", ew, core_m, em); end
                end
            end
            if (core_start) begin
                n_start++;
                st_it = it;
                n_tests++;
                if (core_op !== opc[7:3]) begin n_fail++; $display("FAIL core_op_start: got %0d expected %0d", core_op, opc[7:3]); end
            end
            if (core_abort) begin
                n_abort++;
                abort_at = it - st_it;
            end
            all_v = (!mask[0] || axis_abuff_valid) && (!mask[1] || axis_bbuff_valid) && (!mask[2] || axis_mbuff_valid);
            n_tests++;
            if ((axis_abuff_ready || axis_bbuff_ready || axis_mbuff_ready) && !all_v) begin
                n_fail++; $display("FAIL early_ready: ready %b%b%b before all enabled valid", axis_mbuff_ready, axis_bbuff_ready, axis_abuff_ready);
            end
            n_tests++;
            if ((!mask[0] && axis_abuff_ready) || (!mask[1] && axis_bbuff_ready) || (!mask[2] && axis_mbuff_ready)) begin
                n_fail++; $display("FAIL disabled_ready: ready %b%b%b mask %b", axis_mbuff_ready, axis_bbuff_ready, axis_abuff_ready, mask);
            end
            if (acc) begin
                n_tests++;
                if (axis_opcode_ready !== 1'b0) begin n_fail++; $display("FAIL opcode_ready_busy: got 1 expected 0 at iter %0d", it); end
            end
            if (axis_status_valid) begin
                if (sv_it < 0) begin
                    sv_it = it; held = axis_status_data; lat = sv_it - acc_it;
                end else begin
                    n_tests++;
                    if (axis_status_data !== held) begin n_fail++; $display("FAIL status_hold: got %b expected %b", axis_status_data, held); end
                end
            end
            axis_opcode_data  = opc;
            axis_opcode_valid = !acc || hold_opc;
            axis_abuff_valid  = mask[0] ? (ia < NWORDS) : 1'b1;
            axis_abuff_data   = mask[0] ? ((ia < NWORDS) ? wa[ia] : '0) : DATAW'($urandom);
            axis_bbuff_valid  = mask[1] ? (ib < NWORDS && it >= b_delay) : 1'b1;
            axis_bbuff_data   = mask[1] ? ((ib < NWORDS) ? wb[ib] : '0) : DATAW'($urandom);
            axis_mbuff_valid  = mask[2] ? (im < NWORDS) : 1'b1;
            axis_mbuff_data   = mask[2] ? ((im < NWORDS) ? wm[im] : '0) : DATAW'($urandom);
            core_done         = (done_after > 0 && st_it >= 0 && it == st_it + done_after);
            core_err          = err && core_done;
            axis_status_ready = (sr_delay == 0) ? 1'b1 : (sv_it >= 0 && it >= sv_it + sr_delay);
            #1;
            if (axis_opcode_valid && axis_opcode_ready && !acc) begin acc = 1; acc_it = it; end
            if (axis_abuff_valid && axis_abuff_ready && mask[0]) ia++;
            if (axis_bbuff_valid && axis_bbuff_ready && mask[1]) ib++;
            if (axis_mbuff_valid && axis_mbuff_ready && mask[2]) im++;
            if (axis_status_valid && axis_status_ready) begin
                fin = 1;
                got_s = axis_status_data;
                n_tests++;
                if (qs.size() == 0) begin
                    n_fail++; $display("FAIL status_unexpected: got %b with empty scoreboard", got_s);
                end else begin
                    exp_s = qs.pop_front();
                    if (got_s !== exp_s) begin n_fail++; $display("FAIL status opc=%h: got %b expected %b", opc, got_s, exp_s); end
                end
                if (mask != 3'b000) begin
                    n_tests++;
                    if (core_op !== opc[7:3]) begin n_fail++; $display("FAIL core_op_report: got %0d expected %0d", core_op, opc[7:3]); end
                end
            end
            it++;
        end
        if (!fin) begin
            n_tests++; n_fail++;
            $display("FAIL run_timeout opc=%h: no status handshake within 700 cycles", opc);
        end
        @(negedge axis_clk);
        idle_inputs();
        qa.delete(); qb.delete(); qm.delete(); qw.delete(); qs.delete();
    endtask

    task automatic check_all_zero(input string tag);
        logic [7:0] flags;
        flags = {axis_opcode_ready, axis_abuff_ready, axis_bbuff_ready, axis_mbuff_ready,
                 core_wr, core_start, core_abort, axis_status_valid};
        n_tests++;
        if (flags !== 8'h00) begin n_fail++; $display("FAIL %s_flags: got %b expected 00000000", tag, flags); end
        n_tests++;
        if ({core_op, core_widx, axis_status_data} !== '0) begin
            n_fail++; $display("FAIL %s_fields: op %0d widx %0d status %b, all expected 0", tag, core_op, core_widx, axis_status_data);
        end
        n_tests++;
        if ({core_a, core_b, core_m} !== '0) begin
            n_fail++; $display("FAIL %s_words: got %h %h %h expected 0", tag, core_a, core_b, core_m);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        axis_rstn = 1'b0;
        @(negedge axis_clk);
        check_all_zero("reset");
        @(negedge axis_clk);
        axis_rstn = 1'b1;
        @(negedge axis_clk);
        n_tests++;
        if (axis_opcode_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b expected 1", axis_opcode_ready); end
    endtask

    task automatic test_nop();
        int n_wr, n_start, n_abort, abort_at, lat, first_wr;
        run_op(8'h00, 0, -1, 1'b0, 0, 1'b0, n_wr, n_start, n_abort, abort_at, lat, first_wr);
        n_tests++;
        if (lat !== 2) begin n_fail++; $display("FAIL nop_latency: valid %0d cycles after accept cycle, expected 2", lat); end
        n_tests++;
        if (n_start !== 0 || n_wr !== 0) begin n_fail++; $display("FAIL nop_core: start %0d wr %0d expected 0 0", n_start, n_wr); end
    endtask

    task automatic test_two_stream();
        int n_wr, n_start, n_abort, abort_at, lat, first_wr;
        run_op(8'h0B, 5, 3, 1'b0, 0, 1'b0, n_wr, n_start, n_abort, abort_at, lat, first_wr);
        n_tests++;
        if (n_wr !== 4) begin n_fail++; $display("FAIL ab_wr_count: got %0d expected 4", n_wr); end
        n_tests++;
        if (n_start !== 1) begin n_fail++; $display("FAIL ab_start_count: got %0d expected 1", n_start); end
        n_tests++;
        if (first_wr !== 6) begin n_fail++; $display("FAIL ab_first_wr: got iter %0d expected 6", first_wr); end
    endtask

    task automatic test_core_err();
        int n_wr, n_start, n_abort, abort_at, lat, first_wr;
        run_op(8'h17, 0, 10, 1'b1, 0, 1'b0, n_wr, n_start, n_abort, abort_at, lat, first_wr);
        n_tests++;
        if (n_wr !== 4 || n_start !== 1) begin n_fail++; $display("FAIL abm_counts: wr %0d start %0d expected 4 1", n_wr, n_start); end
        n_tests++;
        if (n_abort !== 0) begin n_fail++; $display("FAIL abm_abort: got %0d expected 0", n_abort); end
    endtask

    task automatic test_timeout();
        int n_wr, n_start, n_abort, abort_at, lat, first_wr;
        run_op(8'h09, 0, -1, 1'b0, 0, 1'b0, n_wr, n_start, n_abort, abort_at, lat, first_wr);
        n_tests++;
        if (n_abort !== 1) begin n_fail++; $display("FAIL tout_abort_count: got %0d expected 1", n_abort); end
        n_tests++;
        // WAIT cycle 255 is the 256th cycle after the core_start cycle
        if (abort_at !== 256) begin n_fail++; $display("FAIL tout_abort_time: got %0d expected 256", abort_at); end
    endtask

    task automatic test_illegal_hold();
        int n_wr, n_start, n_abort, abort_at, lat, first_wr;
        run_op(8'h08, 0, -1, 1'b0, 7, 1'b1, n_wr, n_start, n_abort, abort_at, lat, first_wr);
        n_tests++;
        if (n_wr !== 0 || n_start !== 0 || n_abort !== 0) begin
            n_fail++; $display("FAIL illegal_core: wr %0d start %0d abort %0d expected 0 0 0", n_wr, n_start, n_abort);
        end
    endtask

    task automatic test_reset_mid();
        int n_wr, n_start, n_abort, abort_at, lat, first_wr;
        bit found;
        @(negedge axis_clk);
        axis_opcode_data  = 8'h0F;
        axis_opcode_valid = 1'b1;
        axis_abuff_valid  = 1'b1; axis_abuff_data = 16'h1111;
        axis_bbuff_valid  = 1'b1; axis_bbuff_data = 16'h2222;
        axis_mbuff_valid  = 1'b1; axis_mbuff_data = 16'h3333;
        axis_status_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge axis_clk);
            axis_opcode_valid = 1'b0;
            if (core_wr && core_widx == 1) found = 1;
        end
        n_tests++;
        if (!found) begin n_fail++; $display("FAIL rstmid_reach: widx 1 never written, got none expected 1"); end
        axis_rstn = 1'b0;
        #1;
        check_all_zero("rstmid");
        @(negedge axis_clk);
        @(negedge axis_clk);
        idle_inputs();
        axis_rstn = 1'b1;
        @(negedge axis_clk);
        run_op(8'h0F, 0, 4, 1'b0, 0, 1'b0, n_wr, n_start, n_abort, abort_at, lat, first_wr);
        n_tests++;
        if (n_wr !== 4 || n_start !== 1) begin n_fail++; $display("FAIL rstmid_fresh: wr %0d start %0d expected 4 1", n_wr, n_start); end
    endtask

    initial begin
        test_reset();
        test_nop();
        test_two_stream();
        test_core_err();
        test_timeout();
        test_illegal_hold();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
